// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver
//
// Serial frame receiver. The line is synchronous to Clk_S and carries one bit
// per cycle: idle 0, start bit 1, DATA_W payload bits LSB first, stop bit 0.
// A received word is offered to the consumer through a valid/ready holding
// register. The line is never back-pressured: a good frame that arrives while
// the holding register is full and not being drained is dropped and flagged.
//
// Parameters
//   DATA_W        payload bits per frame
//   CNT_W         bit-counter width, 2**CNT_W > DATA_W
//
// Ports
//   Clk_S         in   clock, all logic on its rising edge
//   Rst           in   synchronous active-high reset
//   S_Data        in   serial line
//   RX_Ready      in   consumer can accept a word
//   RX_Data       out  received payload (DATA_W bits)
//   RX_Data_Valid out  RX_Data holds an unconsumed word
//   Frame_Err     out  one-cycle pulse after a bad stop bit
//   Overrun       out  one-cycle pulse when a good frame is dropped
// ---------------------------------------------------------------------------
module receiver #(
   parameter int DATA_W = 55,
   parameter int CNT_W  = 6
) (
   input  logic              Clk_S,
   input  logic              Rst,
   input  logic              S_Data,
   input  logic              RX_Ready,
   output logic [DATA_W-1:0] RX_Data,
   output logic              RX_Data_Valid,
   output logic              Frame_Err,
   output logic              Overrun
);

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StStop
   } state_t;

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_rx_data;
   logic                r_rx_valid;
   logic                r_frame_err;
   logic                r_overrun;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic [DATA_W-1:0]   w_rx_data_nxt;
   logic                w_rx_valid_nxt;
   logic                w_good;
   logic                w_bad;
   logic                w_xfer;
   logic                w_load;

   // Frame state machine: next state, counter and shift register.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         StIdle: begin
            if (S_Data) begin
               w_state_nxt = StData;
               w_cnt_nxt   = '0;
            end
         end
         StData: begin
            // Counter past the last index can only come from corruption;
            // abandon the frame rather than write out of range.
            if (r_cnt > LastIdx) begin
               w_state_nxt = StIdle;
            end else begin
               w_shift_nxt[r_cnt] = S_Data;
               w_cnt_nxt          = r_cnt + 1'b1;
               if (r_cnt == LastIdx) begin
                  w_state_nxt = StStop;
               end
            end
         end
         StStop: begin
            w_state_nxt = StIdle;
            if (S_Data) begin
               w_bad = 1'b1;
            end else begin
               w_good = 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Holding register: a good frame loads if the register is empty or is
   // being drained in the same cycle; otherwise it is dropped.
   always_comb begin
      w_xfer         = r_rx_valid & RX_Ready;
      w_load         = w_good & (~r_rx_valid | RX_Ready);
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = r_rx_valid;
      if (w_load) begin
         w_rx_data_nxt  = r_shift;
         w_rx_valid_nxt = 1'b1;
      end else if (w_xfer) begin
         w_rx_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge Clk_S) begin
      if (Rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_bad;
         r_overrun   <= w_good & r_rx_valid & ~RX_Ready;
      end
   end

   assign RX_Data       = r_rx_data;
   assign RX_Data_Valid = r_rx_valid;
   assign Frame_Err     = r_frame_err;
   assign Overrun       = r_overrun;

endmodule

// File: tb/tb_receiver.sv
// ---------------------------------------------------------------------------
// tb_receiver
//
// Self-checking bench for receiver. A table of single frames (value, stop
// bit, expected outputs) is applied in a loop, followed by hand-written
// sequences for hold/handshake, back-to-back frames, overrun, frame error
// recovery and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_receiver;

   localparam int DATA_W = 55;
   localparam int CNT_W  = 6;

   logic              Clk_S;
   logic              Rst;
   logic              S_Data;
   logic              RX_Ready;
   logic [DATA_W-1:0] RX_Data;
   logic              RX_Data_Valid;
   logic              Frame_Err;
   logic              Overrun;

   int checks   = 0;
   int failures = 0;

   receiver #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .Clk_S         (Clk_S),
      .Rst           (Rst),
      .S_Data        (S_Data),
      .RX_Ready      (RX_Ready),
      .RX_Data       (RX_Data),
      .RX_Data_Valid (RX_Data_Valid),
      .Frame_Err     (Frame_Err),
      .Overrun       (Overrun)
   );

   initial Clk_S = 1'b0;
   always #5 Clk_S = ~Clk_S;

   typedef struct {
      logic [63:0] value;
      logic        stop;
      logic        exp_valid;
      logic [63:0] exp_data;
      logic        exp_ferr;
   } vec_t;

   vec_t vecs [7];

   // Advance one clock; outputs are sampled and inputs driven 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge Clk_S);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Start bit, payload LSB first, then stop bit with RX_Ready = rdy_stop.
   // Returns with the stop bit sampled and the line idle but not yet clocked,
   // so a following call produces a back-to-back frame.
   task automatic send_frame(input logic [63:0] v, input logic stop, input logic rdy_stop);
      S_Data = 1'b1;
      tick();
      for (int i = 0; i < DATA_W; i++) begin
         S_Data = v[i];
         tick();
      end
      RX_Ready = rdy_stop;
      S_Data   = stop;
      tick();
      RX_Ready = 1'b0;
      S_Data   = 1'b0;
   endtask

   task automatic drain();
      RX_Ready = 1'b1;
      tick();
      RX_Ready = 1'b0;
      check("drain_valid", {63'd0, RX_Data_Valid}, 64'd0);
   endtask

   task automatic check_data(input string name, input logic [63:0] exp);
      check(name, {{(64 - DATA_W){1'b0}}, RX_Data}, exp);
   endtask

   initial begin
      vecs[0] = '{64'h0055_5555_5555_5555, 1'b0, 1'b1, 64'h0055_5555_5555_5555, 1'b0};
      vecs[1] = '{64'h0000_0000_0000_0001, 1'b0, 1'b1, 64'h0000_0000_0000_0001, 1'b0};
      vecs[2] = '{64'h007F_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h007F_FFFF_FFFF_FFFF, 1'b0};
      // Bad stop bit: held word from the previous entry stays, Valid stays 0.
      vecs[3] = '{64'h0000_0000_0000_ABCD, 1'b1, 1'b0, 64'h007F_FFFF_FFFF_FFFF, 1'b1};
      vecs[4] = '{64'h0000_0000_0000_0000, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 1'b0};
      vecs[5] = '{64'h002A_AAAA_AAAA_AAAA, 1'b0, 1'b1, 64'h002A_AAAA_AAAA_AAAA, 1'b0};
      vecs[6] = '{64'h0040_0000_0000_0000, 1'b0, 1'b1, 64'h0040_0000_0000_0000, 1'b0};

      Rst      = 1'b1;
      S_Data   = 1'b0;
      RX_Ready = 1'b0;

      // Reset held two cycles with the line toggling.
      tick();
      S_Data   = 1'b1;
      RX_Ready = 1'b1;
      tick();
      S_Data   = 1'b0;
      check("rst_data", {{(64 - DATA_W){1'b0}}, RX_Data}, 64'd0);
      check("rst_valid", {63'd0, RX_Data_Valid}, 64'd0);
      check("rst_ferr", {63'd0, Frame_Err}, 64'd0);
      check("rst_ovr", {63'd0, Overrun}, 64'd0);
      Rst      = 1'b0;
      RX_Ready = 1'b0;
      tick();
      check("idle_valid", {63'd0, RX_Data_Valid}, 64'd0);

      // Table of single frames, each starting from an empty holding register.
      for (int k = 0; k < 7; k++) begin
         drain();
         send_frame(vecs[k].value, vecs[k].stop, 1'b0);
         check($sformatf("vec%0d_valid", k), {63'd0, RX_Data_Valid}, {63'd0, vecs[k].exp_valid});
         check_data($sformatf("vec%0d_data", k), vecs[k].exp_data);
         check($sformatf("vec%0d_ferr", k), {63'd0, Frame_Err}, {63'd0, vecs[k].exp_ferr});
         check($sformatf("vec%0d_ovr", k), {63'd0, Overrun}, 64'd0);
         tick();
         check($sformatf("vec%0d_ferr_pulse", k), {63'd0, Frame_Err}, 64'd0);
      end

      // Hold until RX_Ready, then Valid drops the next cycle.
      drain();
      send_frame(64'h0055_5555_5555_5555, 1'b0, 1'b0);
      for (int h = 0; h < 4; h++) begin
         check($sformatf("hold%0d_valid", h), {63'd0, RX_Data_Valid}, 64'd1);
         check_data($sformatf("hold%0d_data", h), 64'h0055_5555_5555_5555);
         tick();
      end
      RX_Ready = 1'b1;
      tick();
      RX_Ready = 1'b0;
      check("xfer_valid", {63'd0, RX_Data_Valid}, 64'd0);

      // Back-to-back: A held, B arrives with RX_Ready on its stop cycle.
      send_frame(64'h1, 1'b0, 1'b0);
      check("b2b_a_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check_data("b2b_a_data", 64'h1);
      send_frame(64'h007F_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      check("b2b_b_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check_data("b2b_b_data", 64'h007F_FFFF_FFFF_FFFF);
      check("b2b_ovr", {63'd0, Overrun}, 64'd0);
      tick();
      check("b2b_ovr_after", {63'd0, Overrun}, 64'd0);

      // Overrun: two frames with RX_Ready low throughout.
      drain();
      send_frame(64'h0000_0000_0012_3456, 1'b0, 1'b0);
      send_frame(64'h0000_0000_0065_4321, 1'b0, 1'b0);
      check("ovr_pulse", {63'd0, Overrun}, 64'd1);
      check("ovr_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check_data("ovr_keep", 64'h0000_0000_0012_3456);
      tick();
      check("ovr_one_cycle", {63'd0, Overrun}, 64'd0);
      check_data("ovr_keep2", 64'h0000_0000_0012_3456);

      // Frame error followed by a good frame.
      drain();
      send_frame(64'h0000_0000_0000_0F0F, 1'b1, 1'b0);
      check("ferr_pulse", {63'd0, Frame_Err}, 64'd1);
      check("ferr_valid", {63'd0, RX_Data_Valid}, 64'd0);
      send_frame(64'h0000_0000_0000_3C3C, 1'b0, 1'b0);
      check("ferr_next_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check_data("ferr_next_data", 64'h0000_0000_0000_3C3C);
      check("ferr_next_ferr", {63'd0, Frame_Err}, 64'd0);

      // Reset at data bit 30, then a full frame.
      S_Data = 1'b1;
      tick();
      for (int i = 0; i < 30; i++) begin
         S_Data = 1'b1;
         tick();
      end
      Rst = 1'b1;
      tick();
      check("mid_rst_data", {{(64 - DATA_W){1'b0}}, RX_Data}, 64'd0);
      check("mid_rst_valid", {63'd0, RX_Data_Valid}, 64'd0);
      Rst    = 1'b0;
      S_Data = 1'b0;
      tick();
      check("mid_rst_ferr", {63'd0, Frame_Err}, 64'd0);
      check("mid_rst_ovr", {63'd0, Overrun}, 64'd0);
      check("mid_rst_idle_valid", {63'd0, RX_Data_Valid}, 64'd0);
      send_frame(64'h0000_0000_0000_ABCD, 1'b0, 1'b0);
      check("post_rst_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check_data("post_rst_data", 64'h0000_0000_0000_ABCD);
      check("post_rst_ferr", {63'd0, Frame_Err}, 64'd0);
      check("post_rst_ovr", {63'd0, Overrun}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
